// File: rtl/serdesphy_link_seq.sv
// SerDes PHY link bring-up sequencer: PLL reset/lock, CDR lock, PRBS training,
// link-up supervision with bounded retries. Single clock domain (24 MHz reference).
module serdesphy_link_seq #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RST_CYCLES   = 48,
    parameter int unsigned LOCK_STABLE  = 240,
    parameter int unsigned PLL_TIMEOUT  = 24000,
    parameter int unsigned CDR_TIMEOUT  = 24000,
    parameter int unsigned TRAIN_CYCLES = 4096,
    parameter int unsigned ERR_MAX      = 4,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clk_ref_24m,
    input  logic       rst_n,
    input  logic       phy_en,
    input  logic       power_good,
    input  logic       pll_lock,
    input  logic       cdr_lock,
    input  logic       prbs_err,
    output logic       pll_rst,
    output logic       cdr_rst,
    output logic       tx_en,
    output logic       rx_en,
    output logic       prbs_en,
    output logic       link_up,
    output logic       seq_error,
    output logic [2:0] seq_state,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLL_RST  = 3'd1,
        PLL_WAIT = 3'd2,
        CDR_WAIT = 3'd3,
        TRAIN    = 3'd4,
        LINK_UP  = 3'd5,
        FAULT    = 3'd6
    } state_t;

    // Terminal counts: a phase lasting N cycles exits when the counter shows N-1.
    localparam logic [CNT_W-1:0] RST_TC   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_TC  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] PLL_TC   = CNT_W'(PLL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CDR_TC   = CNT_W'(CDR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TRAIN_TC = CNT_W'(TRAIN_CYCLES - 1);
    localparam logic [7:0]       ERR_LIM  = 8'(ERR_MAX);
    localparam logic [1:0]       RETRY_LAST = 2'(MAX_RETRY - 1);

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt, stab;
    logic [7:0]       err, err_sat;
    logic [1:0]       retry_nxt;
    logic [1:0]       pll_sync, cdr_sync;
    logic             pll_lock_s, cdr_lock_s;
    logic             retry;

    assign pll_lock_s = pll_sync[1];
    assign cdr_lock_s = cdr_sync[1];

    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            pll_sync <= '0;
            cdr_sync <= '0;
        end else begin
            pll_sync <= {pll_sync[0], pll_lock};
            cdr_sync <= {cdr_sync[0], cdr_lock};
        end
    end

    always_comb begin
        nxt     = state;
        retry   = 1'b0;
        err_sat = (prbs_err && err != '1) ? err + 8'd1 : err;
        case (state)
            IDLE:     if (phy_en && power_good) nxt = PLL_RST;
            PLL_RST:  if (cnt == RST_TC) nxt = PLL_WAIT;
            PLL_WAIT: begin
                if (pll_lock_s && stab == STAB_TC) nxt = CDR_WAIT;
                else if (cnt == PLL_TC)            retry = 1'b1;
            end
            CDR_WAIT: begin
                if (!pll_lock_s)                        retry = 1'b1;
                else if (cdr_lock_s && stab == STAB_TC) nxt = TRAIN;
                else if (cnt == CDR_TC)                 retry = 1'b1;
            end
            TRAIN: begin
                if (!pll_lock_s || !cdr_lock_s) retry = 1'b1;
                else if (cnt == TRAIN_TC) begin
                    if (err_sat <= ERR_LIM) nxt = LINK_UP;
                    else                    retry = 1'b1;
                end
            end
            LINK_UP: begin
                if (!pll_lock_s)      retry = 1'b1;
                else if (!cdr_lock_s) nxt = CDR_WAIT;
            end
            FAULT:   nxt = FAULT;
            default: nxt = IDLE;
        endcase

        retry_nxt = retry_cnt;
        if (retry) begin
            if (retry_cnt == RETRY_LAST) begin
                nxt = FAULT;
            end else begin
                nxt       = PLL_RST;
                retry_nxt = retry_cnt + 2'd1;
            end
        end
        if (nxt == LINK_UP && state != LINK_UP) retry_nxt = '0;
        if (!phy_en || !power_good) begin
            nxt       = IDLE;
            retry_nxt = '0;
        end
    end

    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            stab      <= '0;
            err       <= '0;
            retry_cnt <= '0;
            seq_state <= '0;
            pll_rst   <= 1'b1;
            cdr_rst   <= 1'b1;
            tx_en     <= 1'b0;
            rx_en     <= 1'b0;
            prbs_en   <= 1'b0;
            link_up   <= 1'b0;
            seq_error <= 1'b0;
        end else begin
            state     <= nxt;
            seq_state <= nxt;
            retry_cnt <= retry_nxt;

            if (nxt != state) begin
                cnt  <= '0;
                stab <= '0;
                err  <= '0;
            end else begin
                // Counting only in bounded phases keeps the phase counter from wrapping.
                case (state)
                    PLL_RST, PLL_WAIT, CDR_WAIT, TRAIN: cnt <= cnt + 1'b1;
                    default:                            cnt <= cnt;
                endcase
                case (state)
                    PLL_WAIT: stab <= pll_lock_s ? stab + 1'b1 : '0;
                    CDR_WAIT: stab <= cdr_lock_s ? stab + 1'b1 : '0;
                    default:  stab <= '0;
                endcase
                if (state == TRAIN) err <= err_sat;
            end

            pll_rst   <= 1'b0;
            cdr_rst   <= 1'b0;
            tx_en     <= 1'b0;
            rx_en     <= 1'b0;
            prbs_en   <= 1'b0;
            link_up   <= 1'b0;
            seq_error <= 1'b0;
            case (nxt)
                PLL_WAIT: cdr_rst <= 1'b1;
                CDR_WAIT: begin
                    // Re-entry from LINK_UP on CDR loss gives the CDR a one-cycle reset kick.
                    cdr_rst <= (state == LINK_UP);
                    tx_en   <= 1'b1;
                    rx_en   <= 1'b1;
                end
                TRAIN: begin
                    tx_en   <= 1'b1;
                    rx_en   <= 1'b1;
                    prbs_en <= 1'b1;
                end
                LINK_UP: begin
                    tx_en   <= 1'b1;
                    rx_en   <= 1'b1;
                    link_up <= 1'b1;
                end
                FAULT: begin
                    pll_rst   <= 1'b1;
                    cdr_rst   <= 1'b1;
                    seq_error <= 1'b1;
                end
                default: begin
                    pll_rst <= 1'b1;
                    cdr_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serdesphy_link_seq.sv
// Directed bench for serdesphy_link_seq; PLL/CDR modelled as locking whenever their reset is low.
module tb_serdesphy_link_seq;

    logic       clk_ref_24m = 1'b0;
    logic       rst_n;
    logic       phy_en;
    logic       power_good;
    logic       pll_lock;
    logic       cdr_lock;
    logic       prbs_err;
    logic       pll_rst;
    logic       cdr_rst;
    logic       tx_en;
    logic       rx_en;
    logic       prbs_en;
    logic       link_up;
    logic       seq_error;
    logic [2:0] seq_state;
    logic [1:0] retry_cnt;

    logic       pll_ok;
    logic       cdr_ok;
    logic [6:0] ctl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_ref_24m = ~clk_ref_24m;

    assign pll_lock = pll_ok & ~pll_rst;
    assign cdr_lock = cdr_ok & ~cdr_rst;
    assign ctl = {pll_rst, cdr_rst, tx_en, rx_en, prbs_en, link_up, seq_error};

    serdesphy_link_seq #(
        .CNT_W(16),
        .RST_CYCLES(4),
        .LOCK_STABLE(8),
        .PLL_TIMEOUT(64),
        .CDR_TIMEOUT(64),
        .TRAIN_CYCLES(32),
        .ERR_MAX(1),
        .MAX_RETRY(3)
    ) dut (
        .clk_ref_24m(clk_ref_24m),
        .rst_n(rst_n),
        .phy_en(phy_en),
        .power_good(power_good),
        .pll_lock(pll_lock),
        .cdr_lock(cdr_lock),
        .prbs_err(prbs_err),
        .pll_rst(pll_rst),
        .cdr_rst(cdr_rst),
        .tx_en(tx_en),
        .rx_en(rx_en),
        .prbs_en(prbs_en),
        .link_up(link_up),
        .seq_error(seq_error),
        .seq_state(seq_state),
        .retry_cnt(retry_cnt)
    );

    task automatic step();
        @(posedge clk_ref_24m);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget,
                              output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget && !ok) begin
            step();
            cycles++;
            if (seq_state === tgt) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; phy_en = 1'b0; power_good = 1'b0;
        pll_ok = 1'b1; cdr_ok = 1'b1; prbs_err = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({ctl, seq_state, retry_cnt} !== {7'b1100000, 3'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got ctl=%b st=%0d retry=%0d expected ctl=1100000 st=0 retry=0",
                     ctl, seq_state, retry_cnt);
        end
        rst_n = 1'b1;
        repeat (2) step();
        n_checks++;
        if ({ctl, seq_state} !== {7'b1100000, 3'd0}) begin
            n_fail++;
            $display("FAIL idle_disabled: got ctl=%b st=%0d expected ctl=1100000 st=0", ctl, seq_state);
        end
    endtask

    task automatic test_nominal();
        logic [2:0] st [5]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        int         dl [5]  = '{1, 4, 10, 10, 32};
        logic [6:0] cv [5]  = '{7'b1100000, 7'b0100000, 7'b0011000, 7'b0011100, 7'b0011010};
        int cyc;
        bit ok;
        power_good = 1'b1; phy_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_state(st[i], 60, cyc, ok);
            n_checks++;
            if (!ok || cyc != dl[i]) begin
                n_fail++;
                $display("FAIL nominal_latency_st%0d: got %0d cycles (reached=%0d) expected %0d",
                         st[i], cyc, ok, dl[i]);
            end
            n_checks++;
            if (ctl !== cv[i]) begin
                n_fail++;
                $display("FAIL nominal_outputs_st%0d: got ctl=%b expected %b", st[i], ctl, cv[i]);
            end
        end
        n_checks++;
        if (retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL nominal_retry: got %0d expected 0", retry_cnt);
        end
    endtask

    task automatic test_cdr_loss();
        int cyc;
        bit ok;
        cdr_ok = 1'b0;
        wait_state(3'd3, 8, cyc, ok);
        n_checks++;
        if (!ok || cyc != 3) begin
            n_fail++;
            $display("FAIL cdr_loss_latency: got %0d cycles (reached=%0d) expected 3", cyc, ok);
        end
        n_checks++;
        if ({ctl, retry_cnt} !== {7'b0111000, 2'd0}) begin
            n_fail++;
            $display("FAIL cdr_loss_entry: got ctl=%b retry=%0d expected ctl=0111000 retry=0", ctl, retry_cnt);
        end
        step();
        n_checks++;
        if (ctl !== 7'b0011000) begin
            n_fail++;
            $display("FAIL cdr_rst_pulse_end: got ctl=%b expected 0011000", ctl);
        end
        cdr_ok = 1'b1;
        wait_state(3'd5, 80, cyc, ok);
        n_checks++;
        if (!ok || cyc != 42 || retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL cdr_relock: got %0d cycles (reached=%0d) retry=%0d expected 42 cycles retry=0",
                     cyc, ok, retry_cnt);
        end
    endtask

    task automatic test_train_errors();
        int cyc;
        bit ok;
        phy_en = 1'b0;
        step();
        n_checks++;
        if ({seq_state, retry_cnt} !== {3'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL abort_phy_en: got st=%0d retry=%0d expected st=0 retry=0", seq_state, retry_cnt);
        end
        phy_en = 1'b1;
        wait_state(3'd4, 40, cyc, ok);
        n_checks++;
        if (!ok || cyc != 25) begin
            n_fail++;
            $display("FAIL train_entry: got %0d cycles (reached=%0d) expected 25", cyc, ok);
        end
        prbs_err = 1'b1; step(); prbs_err = 1'b0; step();
        prbs_err = 1'b1; step(); prbs_err = 1'b0;
        wait_state(3'd1, 40, cyc, ok);
        n_checks++;
        if (!ok || cyc != 29 || retry_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL train_2err_retry: got %0d cycles (reached=%0d) retry=%0d expected 29 cycles retry=1",
                     cyc, ok, retry_cnt);
        end
        wait_state(3'd4, 40, cyc, ok);
        n_checks++;
        if (!ok || cyc != 24) begin
            n_fail++;
            $display("FAIL retrain_entry: got %0d cycles (reached=%0d) expected 24", cyc, ok);
        end
        prbs_err = 1'b1; step(); prbs_err = 1'b0;
        wait_state(3'd5, 40, cyc, ok);
        n_checks++;
        if (!ok || cyc != 31 || retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL train_1err_linkup: got %0d cycles (reached=%0d) retry=%0d expected 31 cycles retry=0",
                     cyc, ok, retry_cnt);
        end
    endtask

    task automatic test_lock_glitch();
        int cyc;
        bit ok;
        phy_en = 1'b0; step(); phy_en = 1'b1;
        wait_state(3'd2, 10, cyc, ok);
        n_checks++;
        if (!ok || cyc != 5) begin
            n_fail++;
            $display("FAIL glitch_pll_wait_entry: got %0d cycles (reached=%0d) expected 5", cyc, ok);
        end
        repeat (7) step();
        pll_ok = 1'b0; step(); pll_ok = 1'b1;
        wait_state(3'd3, 30, cyc, ok);
        n_checks++;
        if (!ok || cyc != 10) begin
            n_fail++;
            $display("FAIL glitch_requalify: got %0d more cycles (reached=%0d) expected 10 (18 total in PLL_WAIT)",
                     cyc, ok);
        end
    endtask

    task automatic test_pll_timeout();
        int cyc;
        bit ok;
        phy_en = 1'b0; step();
        pll_ok = 1'b0; phy_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_state(3'd2, 10, cyc, ok);
            n_checks++;
            if (!ok || cyc != ((i == 0) ? 5 : 4)) begin
                n_fail++;
                $display("FAIL timeout_pll_wait_entry%0d: got %0d cycles (reached=%0d) expected %0d",
                         i, cyc, ok, (i == 0) ? 5 : 4);
            end
            wait_state((i < 2) ? 3'd1 : 3'd6, 80, cyc, ok);
            n_checks++;
            if (!ok || cyc != 64 || retry_cnt !== 2'((i < 2) ? i + 1 : 2)) begin
                n_fail++;
                $display("FAIL pll_timeout%0d: got %0d cycles (reached=%0d) retry=%0d expected 64 cycles retry=%0d",
                         i, cyc, ok, retry_cnt, (i < 2) ? i + 1 : 2);
            end
        end
        n_checks++;
        if (ctl !== 7'b1100001) begin
            n_fail++;
            $display("FAIL fault_outputs: got ctl=%b expected 1100001", ctl);
        end
        repeat (5) step();
        n_checks++;
        if (seq_state !== 3'd6) begin
            n_fail++;
            $display("FAIL fault_sticky: got st=%0d expected 6", seq_state);
        end
        phy_en = 1'b0; step();
        n_checks++;
        if ({ctl, seq_state, retry_cnt} !== {7'b1100000, 3'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL fault_exit: got ctl=%b st=%0d retry=%0d expected ctl=1100000 st=0 retry=0",
                     ctl, seq_state, retry_cnt);
        end
    endtask

    task automatic test_abort();
        int cyc;
        bit ok;
        pll_ok = 1'b1; phy_en = 1'b1;
        wait_state(3'd4, 40, cyc, ok);
        repeat (3) step();
        n_checks++;
        if (!ok || ctl !== 7'b0011100) begin
            n_fail++;
            $display("FAIL abort_in_train_pre: got ctl=%b (reached=%0d) expected 0011100", ctl, ok);
        end
        power_good = 1'b0; step();
        n_checks++;
        if ({ctl, seq_state, retry_cnt} !== {7'b1100000, 3'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL abort_power_good: got ctl=%b st=%0d retry=%0d expected ctl=1100000 st=0 retry=0",
                     ctl, seq_state, retry_cnt);
        end
        power_good = 1'b1;
    endtask

    task automatic test_async_reset();
        int cyc;
        bit ok;
        wait_state(3'd5, 80, cyc, ok);
        n_checks++;
        if (!ok || cyc != 57) begin
            n_fail++;
            $display("FAIL linkup_before_reset: got %0d cycles (reached=%0d) expected 57", cyc, ok);
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ctl, seq_state, retry_cnt} !== {7'b1100000, 3'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got ctl=%b st=%0d retry=%0d expected ctl=1100000 st=0 retry=0",
                     ctl, seq_state, retry_cnt);
        end
        #2 rst_n = 1'b1;
        step();
        n_checks++;
        if (seq_state !== 3'd1) begin
            n_fail++;
            $display("FAIL post_reset_restart: got st=%0d expected 1", seq_state);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_cdr_loss();
        test_train_errors();
        test_lock_glitch();
        test_pll_timeout();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
